// File: rtl/iobuf_vec_capture_pkg.sv
// Shared types for the IOBUF-vector capture path: the NOC beat layout and the
// capture FSM states.
package iobuf_vec_capture_pkg;

  localparam int NOC_DATA_W = 128;
  localparam int NOC_LEN_W  = 16;

  typedef struct packed {
    logic [NOC_DATA_W-1:0] data;
    logic [NOC_LEN_W-1:0]  length;
  } noc_data_h_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/iobuf_vec_sync.sv
// Two-flop synchroniser for a bank of asynchronous pad inputs; shared with the
// IOBUF-vector pin driver.
module iobuf_vec_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] sync_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p1 <= d;
      sync_p2 <= sync_p1;
    end
  end

  assign q = sync_p2;

endmodule

// File: rtl/iobuf_vec_capture.sv
// Receive-side IOBUF-vector capture: keeps the pads in input mode, samples them
// every CLK_DIV cycles and packs the samples LSB-first into NOC beats.
module iobuf_vec_capture
  import iobuf_vec_capture_pkg::*;
#(
  parameter int IOVEC_WIDTH = 8,
  parameter int CLK_DIV     = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [IOVEC_WIDTH-1:0] pins_O,
  output logic                   pins_T,
  input  logic                   ctl_enq__ENA,
  input  logic [15:0]            ctl_enq_v,
  output logic                   ctl_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [143:0]           out_enq_v,
  input  logic                   out_enq__RDY,
  output logic                   overrun
);

  localparam int          SPB      = NOC_DATA_W / IOVEC_WIDTH;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] SPB_LAST = 16'(SPB - 1);

  function automatic logic [NOC_DATA_W-1:0] insert_sample(
    input logic [NOC_DATA_W-1:0]  data,
    input logic [15:0]            idx,
    input logic [IOVEC_WIDTH-1:0] smp
  );
    logic [NOC_DATA_W-1:0] r;
    r = data;
    r[int'(idx)*IOVEC_WIDTH +: IOVEC_WIDTH] = smp;
    return r;
  endfunction

  cap_state_e            state, state_nxt;
  logic [IOVEC_WIDTH-1:0] pins_sync;
  logic [15:0]           div_cnt;
  logic [15:0]           remaining;
  logic [15:0]           samp_cnt;
  logic [NOC_DATA_W-1:0] shift_p0;
  logic [NOC_DATA_W-1:0] beat_data;
  noc_data_h_t           hold_p1;
  logic                  vld_p1;
  logic                  overrun_r;

  logic cmd_fire, sample_now, last_sample, beat_close, out_fire, beat_drop;

  iobuf_vec_sync #(.WIDTH(IOVEC_WIDTH)) u_sync (
    .clk   (CLK),
    .rst_n (nRST),
    .d     (pins_O),
    .q     (pins_sync)
  );

  assign pins_T       = 1'b1;
  assign ctl_enq__RDY = (state == IDLE);
  assign out_enq__ENA = vld_p1 & out_enq__RDY;
  assign out_enq_v    = hold_p1;
  assign overrun      = overrun_r;

  assign cmd_fire    = ctl_enq__ENA & ctl_enq__RDY;
  assign out_fire    = vld_p1 & out_enq__RDY;
  assign sample_now  = (state == CAPTURE) && (div_cnt == 16'd0);
  assign last_sample = sample_now && (remaining == 16'd1);
  assign beat_close  = sample_now && ((samp_cnt == SPB_LAST) || (remaining == 16'd1));
  // Sampling never stalls: a beat that finds the holding register occupied is lost.
  assign beat_drop   = beat_close && vld_p1 && !out_fire;
  assign beat_data   = insert_sample(shift_p0, samp_cnt, pins_sync);

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = (ctl_enq_v == 16'd0) ? FLUSH : CAPTURE;
      CAPTURE: if (last_sample) state_nxt = FLUSH;
      FLUSH:   if (!vld_p1 || out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: divider, sample counting and the pack register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      div_cnt   <= '0;
      remaining <= '0;
      samp_cnt  <= '0;
      shift_p0  <= '0;
    end else if (cmd_fire) begin
      div_cnt   <= '0;
      remaining <= ctl_enq_v;
      samp_cnt  <= '0;
      shift_p0  <= '0;
    end else if (state == CAPTURE) begin
      div_cnt <= (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;
      if (sample_now) begin
        if (remaining != 16'd0) remaining <= remaining - 16'd1;
        if (beat_close) begin
          samp_cnt <= '0;
          shift_p0 <= '0;
        end else begin
          samp_cnt <= samp_cnt + 16'd1;
          shift_p0 <= beat_data;
        end
      end
    end
  end

  // Stage p1: holding register toward the NOC and the sticky overrun flag
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_p1   <= '0;
      vld_p1    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (beat_close && !beat_drop) begin
        hold_p1.data   <= beat_data;
        hold_p1.length <= samp_cnt + 16'd1;
        vld_p1         <= 1'b1;
      end else if (out_fire) begin
        vld_p1 <= 1'b0;
      end
      if (cmd_fire)       overrun_r <= 1'b0;
      else if (beat_drop) overrun_r <= 1'b1;
    end
  end

endmodule
